// File: rtl/l1_responder.sv
// Single-outstanding L1 lookup responder over a preloadable word memory.
// Define L1_RESP_MISS_EN to build the direct-mapped tag array and miss path.
module l1_responder #(
    parameter int AW       = 8,
    parameter int IW       = 4,
    parameter int MISS_LAT = 6
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic [27:0]   l1_va_i,
    input  logic          l1_va_vld_i,
    input  logic          l1_cancel_i,
    output logic [31:0]   l1_pa_o,
    output logic          l1_vld_o,
    output logic          busy_o,
    output logic          proto_err_o,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [31:0]   mem_wdata_i,
    output logic [15:0]   hit_cnt_o,
    output logic [15:0]   miss_cnt_o
);
    localparam int TW = 26 - IW;
    localparam logic [3:0] WAIT_INIT = 4'(MISS_LAT - 3);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [27:0]   va_q, va_d;
    logic [31:0]   pa_q, pa_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;
    logic [15:0]   hit_q, hit_d;
    logic [15:0]   miss_q, miss_d;
    logic [3:0]    wait_q, wait_d;
    logic [31:0]   mem [2**AW];
    logic [AW-1:0] word_idx;
    logic [31:0]   rdata;
    logic          lookup_hit;
    logic          fill;
    logic          busy_resp;
    logic          unused_va;

    assign word_idx  = va_q[AW+1:2];
    assign rdata     = mem[word_idx];
    assign fill      = (state_q == MISS_WAIT) && (wait_q == 4'd0);
    assign busy_resp = (state_q != IDLE) || vld_q;
    assign unused_va = ^va_q;

`ifdef L1_RESP_MISS_EN
    logic [TW-1:0]    tag_mem [2**IW];
    logic [2**IW-1:0] tv_q, tv_d;
    logic [IW-1:0]    line_idx;
    logic [TW-1:0]    va_tag;

    assign line_idx   = va_q[IW+1:2];
    assign va_tag     = va_q[27:IW+2];
    assign lookup_hit = tv_q[line_idx] && (tag_mem[line_idx] == va_tag);

    always_comb begin
        tv_d = tv_q;
        if (fill) begin
            tv_d[line_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            tv_q <= '0;
        end else begin
            tv_q <= tv_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_mem[line_idx] <= va_tag;
        end
    end

    assign miss_cnt_o = miss_q;
`else
    logic unused_miss;

    assign lookup_hit  = 1'b1;
    assign miss_cnt_o  = 16'h0;
    assign unused_miss = ^miss_q;
`endif

    always_comb begin
        state_d = state_q;
        va_d    = va_q;
        pa_d    = pa_q;
        vld_d   = 1'b0;
        err_d   = err_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        wait_d  = wait_q;
        // A request in the response cycle still counts as busy
        if (l1_va_vld_i && busy_resp) begin
            err_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (l1_va_vld_i && !vld_q) begin
                    va_d    = l1_va_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (l1_cancel_i) begin
                    state_d = IDLE;
                end else if (lookup_hit) begin
                    pa_d    = rdata;
                    vld_d   = 1'b1;
                    state_d = IDLE;
                    if (hit_q != 16'hFFFF) begin
                        hit_d = hit_q + 16'd1;
                    end
                end else begin
                    wait_d  = WAIT_INIT;
                    state_d = MISS_WAIT;
                    if (miss_q != 16'hFFFF) begin
                        miss_d = miss_q + 16'd1;
                    end
                end
            end
            MISS_WAIT: begin
                if (fill) begin
                    pa_d    = rdata;
                    vld_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            va_q    <= '0;
            pa_q    <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            hit_q   <= '0;
            miss_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            va_q    <= va_d;
            pa_q    <= pa_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            wait_q  <= wait_d;
        end
    end

    // Backing store is not reset so preloaded contents survive
    always_ff @(posedge clk_i) begin
        if (mem_we_i) begin
            mem[mem_addr_i] <= mem_wdata_i;
        end
    end

    assign l1_pa_o     = pa_q;
    assign l1_vld_o    = vld_q;
    assign busy_o      = (state_q != IDLE);
    assign proto_err_o = err_q;
    assign hit_cnt_o   = hit_q;
endmodule
